// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mips_pkg
// Description : Shared constants for the MIPS fetch/decode slice.
//               - MIPS opcode values (Instruction[31:26]).
//               - Instruction word width.
//               - Fetch FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam int INSTR_WIDTH = 32;

  // Opcode field values, Instruction[31:26]
  localparam logic [5:0] rType         = 6'b000000;
  localparam logic [5:0] loadWord      = 6'b100011;
  localparam logic [5:0] storeWord     = 6'b101011;
  localparam logic [5:0] addImmediate  = 6'b001000;
  localparam logic [5:0] branchIfEqual = 6'b000100;
  localparam logic [5:0] jump_inst     = 6'b000010;

  // Fetch FSM states
  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/pc_next_logic.sv
`default_nettype none
// ============================================================================
// Module      : pc_next_logic
// Description : Combinational next-PC selection for the fetch stage.
//
//               Jump target   : {pc_plus4[31:28], instruction[25:0], 2'b00}
//               Branch target : pc_plus4 + {sign_imm[29:0], 2'b00}
//               Sequential    : pc_plus4
//
//               Jump has priority over branch. All sums are modulo 2^32.
//
// Ports       : pc          in   32  current PC
//               instruction in   32  instruction being retired
//               sign_imm    in   32  sign-extended immediate
//               jmp         in   1   select jump target
//               pc_src      in   1   select branch target
//               pc_plus4    out  32  pc + 4
//               next_pc     out  32  selected next PC, bits [1:0] always 0
// Revision    : 1.0 - initial release
// ============================================================================
module pc_next_logic
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instruction,
  input  logic [31:0] sign_imm,
  input  logic        jmp,
  input  logic        pc_src,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  logic [31:0] w_jump_target;
  logic [31:0] w_branch_target;
  logic [31:0] w_sel_pc;

  // Only the 26-bit jump index and the low 30 immediate bits shape a target;
  // the upper bits would be shifted out by the <<2 anyway.
  logic unused_bits;
  assign unused_bits = ^{instruction[31:26], sign_imm[31:30]};

  assign pc_plus4        = pc + 32'd4;
  assign w_jump_target   = {pc_plus4[31:28], instruction[25:0], 2'b00};
  assign w_branch_target = pc_plus4 + {sign_imm[29:0], 2'b00};

  always_comb begin
    w_sel_pc = pc_plus4;
    if (jmp) begin
      w_sel_pc = w_jump_target;
    end else if (pc_src) begin
      w_sel_pc = w_branch_target;
    end
  end

  // Keep the PC word aligned even if the current PC were ever misaligned.
  assign next_pc = {w_sel_pc[31:2], 2'b00};

endmodule : pc_next_logic
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Fetch stage feeding the ControlUnit/datapath. Owns the PC,
//               fetches from instruction memory over a req/ack interface,
//               holds the fetched word stable and hands it off with a
//               valid/accept handshake. On accept the PC advances to the
//               target chosen by Jmp/PCSrc for that same instruction.
//
// Ports       : CLK          in   1            clock, rising edge
//               RST          in   1            async active-low reset
//               ImemReq      out  1            fetch request
//               ImemAddr     out  32           fetch byte address (= PC)
//               ImemAck      in   1            ImemRdata valid this cycle
//               ImemRdata    in   INSTR_WIDTH  fetched word
//               Instruction  out  INSTR_WIDTH  held instruction
//               InstrValid   out  1            Instruction valid and stable
//               InstrAccept  in   1            datapath retires instruction
//               Jmp          in   1            take jump target
//               PCSrc        in   1            take branch target
//               SignImm      in   32           sign-extended immediate
//               PC           out  32           current PC
//               PCPlus4      out  32           PC + 4
//               InstrCount   out  CNT_WIDTH    accepted instruction count
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int          INSTR_WIDTH = 32,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          CNT_WIDTH   = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  output logic                   ImemReq,
  output logic [31:0]            ImemAddr,
  input  logic                   ImemAck,
  input  logic [INSTR_WIDTH-1:0] ImemRdata,
  output logic [INSTR_WIDTH-1:0] Instruction,
  output logic                   InstrValid,
  input  logic                   InstrAccept,
  input  logic                   Jmp,
  input  logic                   PCSrc,
  input  logic [31:0]            SignImm,
  output logic [31:0]            PC,
  output logic [31:0]            PCPlus4,
  output logic [CNT_WIDTH-1:0]   InstrCount
);

  localparam logic [31:0] c_RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  fetch_state_t                 r_state;
  fetch_state_t                 w_state_next;
  logic [31:0]                  r_pc;
  logic [INSTR_WIDTH-1:0]       r_instr;
  logic [CNT_WIDTH-1:0]         r_count;
  logic                         w_capture;
  logic                         w_retire;
  logic [31:0]                  w_next_pc;
  logic [31:0]                  w_pc_plus4;

  pc_next_logic u_pc_next_logic (
    .pc          (r_pc),
    .instruction (r_instr),
    .sign_imm    (SignImm),
    .jmp         (Jmp),
    .pc_src      (PCSrc),
    .pc_plus4    (w_pc_plus4),
    .next_pc     (w_next_pc)
  );

  // State register and datapath registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= FETCH;
      r_pc    <= c_RESET_PC_ALIGNED;
      r_instr <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_capture) begin
        r_instr <= ImemRdata;
      end
      if (w_retire) begin
        r_pc    <= w_next_pc;
        r_count <= r_count + CNT_WIDTH'(1);
      end
    end
  end

  // Next-state logic. Ack outside FETCH and accept outside HOLD are ignored.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_retire     = 1'b0;
    case (r_state)
      FETCH: begin
        if (ImemAck) begin
          w_capture    = 1'b1;
          w_state_next = HOLD;
        end
      end
      HOLD: begin
        if (InstrAccept) begin
          w_retire     = 1'b1;
          w_state_next = FETCH;
        end
      end
      default: begin
        w_state_next = FETCH;
      end
    endcase
  end

  // The request is gated by RST so that nothing is requested (and nothing
  // could be acknowledged) while the unit is held in reset.
  assign ImemReq     = RST && (r_state == FETCH);
  assign ImemAddr    = r_pc;
  assign InstrValid  = (r_state == HOLD);
  assign Instruction = r_instr;
  assign PC          = r_pc;
  assign PCPlus4     = w_pc_plus4;
  assign InstrCount  = r_count;

endmodule : instr_fetch_unit
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed self-checking bench for instr_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  logic        CLK;
  logic        RST;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemAck;
  logic [31:0] ImemRdata;
  logic [31:0] Instruction;
  logic        InstrValid;
  logic        InstrAccept;
  logic        Jmp;
  logic        PCSrc;
  logic [31:0] SignImm;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic [31:0] InstrCount;

  int total;
  int bad;

  instr_fetch_unit #(
    .INSTR_WIDTH (32),
    .RESET_PC    (32'h0000_0000),
    .CNT_WIDTH   (32)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .ImemReq     (ImemReq),
    .ImemAddr    (ImemAddr),
    .ImemAck     (ImemAck),
    .ImemRdata   (ImemRdata),
    .Instruction (Instruction),
    .InstrValid  (InstrValid),
    .InstrAccept (InstrAccept),
    .Jmp         (Jmp),
    .PCSrc       (PCSrc),
    .SignImm     (SignImm),
    .PC          (PC),
    .PCPlus4     (PCPlus4),
    .InstrCount  (InstrCount)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample and drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One fetch with same-cycle ack.
  task automatic fetch(input logic [31:0] word);
    chk("fetch_req", 32'(ImemReq), 32'd1);
    ImemAck   = 1'b1;
    ImemRdata = word;
    tick();
    ImemAck   = 1'b0;
    chk("fetch_valid", 32'(InstrValid), 32'd1);
    chk("fetch_instr", Instruction, word);
  endtask

  // One accept with same-cycle handshake, then check PC/count/handoff.
  task automatic accept(input logic j, input logic b, input logic [31:0] imm,
                        input logic [31:0] exp_pc, input logic [31:0] exp_cnt);
    InstrAccept = 1'b1;
    Jmp         = j;
    PCSrc       = b;
    SignImm     = imm;
    tick();
    InstrAccept = 1'b0;
    Jmp         = 1'b0;
    PCSrc       = 1'b0;
    SignImm     = 32'h0;
    chk("acc_pc",    PC,         exp_pc);
    chk("acc_addr",  ImemAddr,   exp_pc);
    chk("acc_count", InstrCount, exp_cnt);
    chk("acc_req",   32'(ImemReq), 32'd1);
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    RST         = 1'b0;
    ImemAck     = 1'b1;
    ImemRdata   = 32'hCAFE_F00D;
    InstrAccept = 1'b0;
    Jmp         = 1'b0;
    PCSrc       = 1'b0;
    SignImm     = 32'h0;

    // ---- 1: reset with ack held high ----
    tick();
    tick();
    chk("rst_pc",     PC,                32'h0);
    chk("rst_req",    32'(ImemReq),      32'd0);
    chk("rst_valid",  32'(InstrValid),   32'd0);
    chk("rst_instr",  Instruction,       32'h0);
    chk("rst_count",  InstrCount,        32'h0);
    chk("rst_plus4",  PCPlus4,           32'h4);
    ImemAck = 1'b0;
    RST     = 1'b1;
    tick();
    chk("rel_req",   32'(ImemReq),    32'd1);
    chk("rel_addr",  ImemAddr,        32'h0);
    chk("rel_valid", 32'(InstrValid), 32'd0);

    // ---- 2: sequential ----
    fetch(32'h0022_1820);                   // add
    accept(1'b0, 1'b0, 32'h0, 32'h4, 32'd1);
    fetch(32'h0022_1820);
    accept(1'b0, 1'b0, 32'h0, 32'h8, 32'd2);
    fetch(32'h0022_1820);
    accept(1'b0, 1'b0, 32'h0, 32'hC, 32'd3);
    fetch(32'h0022_1820);
    accept(1'b0, 1'b0, 32'h0, 32'h10, 32'd4);

    // ---- 3: branches ----
    // 0x14 + (-2 << 2) = 0x0C
    fetch(32'h1000_FFFE);
    accept(1'b0, 1'b1, 32'hFFFF_FFFE, 32'h0C, 32'd5);
    fetch(32'h0022_1820);
    accept(1'b0, 1'b0, 32'h0, 32'h10, 32'd6);
    // 0x14 + (3 << 2) = 0x20
    fetch(32'h1000_0003);
    accept(1'b0, 1'b1, 32'h0000_0003, 32'h20, 32'd7);
    // 0x24 + (0x0400_0007 << 2) = 0x1000_0040
    fetch(32'h1000_0007);
    accept(1'b0, 1'b1, 32'h0400_0007, 32'h1000_0040, 32'd8);

    // ---- 4: jump wins over branch ----
    fetch(32'h0800_0010);
    chk("j_plus4", PCPlus4, 32'h1000_0044);
    accept(1'b1, 1'b1, 32'h0000_0005, 32'h1000_0040, 32'd9);

    // ---- 5: stalls ----
    for (int i = 0; i < 5; i++) begin
      chk("stall_req",   32'(ImemReq),    32'd1);
      chk("stall_addr",  ImemAddr,        32'h1000_0040);
      chk("stall_valid", 32'(InstrValid), 32'd0);
      tick();
    end
    fetch(32'h0BFF_FFFF);
    // held instruction with stray acks on other data
    ImemAck   = 1'b1;
    ImemRdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("hold_instr", Instruction,     32'h0BFF_FFFF);
      chk("hold_valid", 32'(InstrValid), 32'd1);
      chk("hold_req",   32'(ImemReq),    32'd0);
      chk("hold_pc",    PC,              32'h1000_0040);
      chk("hold_cnt",   InstrCount,      32'd9);
    end
    ImemAck = 1'b0;
    // jump: {0x1, 0x3FF_FFFF, 00} = 0x1FFF_FFFC
    accept(1'b1, 1'b0, 32'h0, 32'h1FFF_FFFC, 32'd10);
    // accept while in FETCH is ignored; PC updated exactly once
    InstrAccept = 1'b1;
    tick();
    tick();
    InstrAccept = 1'b0;
    chk("once_pc",  PC,         32'h1FFF_FFFC);
    chk("once_cnt", InstrCount, 32'd10);

    // ---- 6: wrap ----
    // 0x2000_0000 + (0x37FF_FFFF << 2) = 0xFFFF_FFFC
    fetch(32'h1000_FFFF);
    accept(1'b0, 1'b1, 32'h37FF_FFFF, 32'hFFFF_FFFC, 32'd11);
    chk("wrap_plus4", PCPlus4, 32'h0);
    fetch(32'h0022_1820);
    accept(1'b0, 1'b0, 32'h0, 32'h0, 32'd12);
    fetch(32'h0022_1820);
    accept(1'b0, 1'b0, 32'h0, 32'h4, 32'd13);

    // ---- 6: reset during FETCH with ack pending ----
    ImemAck   = 1'b1;
    ImemRdata = 32'h1234_5678;
    RST       = 1'b0;
    #1;
    chk("mrst_pc",    PC,              32'h0);
    chk("mrst_req",   32'(ImemReq),    32'd0);
    chk("mrst_count", InstrCount,      32'h0);
    tick();
    chk("mrst_instr", Instruction,     32'h0);
    chk("mrst_valid", 32'(InstrValid), 32'd0);
    ImemAck = 1'b0;
    RST     = 1'b1;
    tick();
    chk("mrel_req",  32'(ImemReq), 32'd1);
    chk("mrel_addr", ImemAddr,     32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_instr_fetch_unit
`default_nettype wire
